// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one flash read controller between two clients.
// Optional wait-for-done timeout enabled by defining FLASH_ARB_TIMEOUT_EN.
module flash_read_arbiter #(
   parameter int ADDR_W  = 23,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 200,
   parameter int DRAIN   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              err0,
   output logic              err1,
   output logic              mc_start,
   output logic              mc_inread,
   output logic [ADDR_W-1:0] mc_addr,
   input  logic              mc_done,
   input  logic [DATA_W-1:0] mc_data
);

   typedef enum logic [2:0] {
      S_DRAIN,
      S_IDLE,
      S_ISSUE,
      S_WAIT_DONE,
      S_RESPOND
   } state_t;

   localparam int DRAIN_CW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("flash_read_arbiter: TIMEOUT must be in 1..255");
   end

   state_t              state;
   logic [DRAIN_CW-1:0] drain_cnt;
   logic                gnt;
   logic                last;
   logic                pick;

   // With both requesting, the client that was not served last wins.
   assign pick      = (req0 && req1) ? ~last : req1;
   assign mc_inread = 1'b1;

`ifdef FLASH_ARB_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
   logic [7:0] wait_cnt;
`else
   assign err0 = 1'b0;
   assign err1 = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_DRAIN;
         drain_cnt <= DRAIN_CW'(DRAIN - 1);
         last      <= 1'b1;
         gnt       <= 1'b0;
         mc_start  <= 1'b0;
         mc_addr   <= '0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
`ifdef FLASH_ARB_TIMEOUT_EN
         err0      <= 1'b0;
         err1      <= 1'b0;
         wait_cnt  <= '0;
`endif
      end else begin
         mc_start <= 1'b0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
         err0     <= 1'b0;
         err1     <= 1'b0;
`endif
         case (state)
            // Requests and done pulses are ignored while the controller settles.
            S_DRAIN: begin
               if (drain_cnt == '0) begin
                  state <= S_IDLE;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            S_IDLE: begin
               if (req0 || req1) begin
                  gnt      <= pick;
                  mc_addr  <= pick ? addr1 : addr0;
                  mc_start <= 1'b1;
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
`ifdef FLASH_ARB_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (mc_done) begin
                  if (gnt) begin
                     rdata1 <= mc_data;
                     ack1   <= 1'b1;
                  end else begin
                     rdata0 <= mc_data;
                     ack0   <= 1'b1;
                  end
                  state <= S_RESPOND;
               end
`ifdef FLASH_ARB_TIMEOUT_EN
               // The err outputs double as the error flag for the response cycle.
               else if (wait_cnt == TIMEOUT_LAST) begin
                  if (gnt) begin
                     rdata1 <= '0;
                     ack1   <= 1'b1;
                     err1   <= 1'b1;
                  end else begin
                     rdata0 <= '0;
                     ack0   <= 1'b1;
                     err0   <= 1'b1;
                  end
                  state <= S_RESPOND;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
`endif
            end
            S_RESPOND: begin
               last  <= gnt;
               state <= S_IDLE;
            end
            default: begin
               state <= S_DRAIN;
            end
         endcase
      end
   end

endmodule
